// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   UART transmitter for the APB UART slave. Pops bytes from the TX FIFO and
//   sends them on tx_o as: start bit, DATA_BITS data bits LSB first, an
//   optional parity bit, then STOP_BITS stop bits. Bit timing comes from the
//   shared one-cycle baud tick; everything runs on clk_i.
//
//   While a frame's stop bits are on the line, the next byte is prefetched
//   into a hold register so that consecutive frames leave no idle gap.
//
//   Optional feature: define UART_TX_PARITY_EN to add a parity bit after the
//   data bits. Parity sense comes from parity_odd_i (0 = even, 1 = odd).
//
// Ports
//   clk_i           system clock
//   rstn_i          asynchronous active-low reset
//   baud_tick_i     one-cycle pulse per bit period
//   tx_en_i         transmitter enable
//   fifo_E_i        TX FIFO empty
//   fifo_rd_data_i  TX FIFO read data, valid the cycle after rd_en_o
//   parity_odd_i    parity sense (UART_TX_PARITY_EN only)
//   rd_en_o         FIFO pop, one cycle per byte
//   tx_o            serial line, idles high
//   tx_stat_o       {tx_done, tx_busy}
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       baud_tick_i,
    input  logic       tx_en_i,
    input  logic       fifo_E_i,
    input  logic [7:0] fifo_rd_data_i,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_odd_i,
`endif
    output logic       rd_en_o,
    output logic       tx_o,
    output logic [1:0] tx_stat_o
);

    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rd_en_q, rd_en_d;
    // High in the cycle where fifo_rd_data_i carries the byte just popped.
    logic                 pop_dly_q;
    logic                 tx_done;
`ifdef UART_TX_PARITY_EN
    // Running parity: seeded with the parity sense, XORed with every data bit.
    logic                 par_q, par_d;
`endif

    // NOTE: every state register is written with non-blocking assignments
    // only; the next-state values are computed combinationally below.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            pop_dly_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            rd_en_q      <= rd_en_d;
            pop_dly_q    <= rd_en_q;
`ifdef UART_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        tx_d         = tx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;
        rd_en_d      = 1'b0;
        tx_done      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_en_i && !fifo_E_i) begin
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end

            // rd_en_o is high in this cycle; the byte appears in the next.
            FETCH: state_d = LOAD;

            LOAD: begin
                if (pop_dly_q) shift_d = fifo_rd_data_i[DATA_BITS-1:0];
                if (baud_tick_i) begin
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = parity_odd_i;
`endif
                end
            end

            START: begin
                if (baud_tick_i) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = 4'd1;
                    state_d = DATA;
`ifdef UART_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                end
            end

            DATA: begin
                if (baud_tick_i) begin
                    if (cnt_q < DATA_LAST) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 4'd1;
`ifdef UART_TX_PARITY_EN
                        par_d   = par_q ^ shift_q[0];
`endif
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = STOP;
                        rd_en_d = tx_en_i && !fifo_E_i && !hold_valid_q;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick_i) begin
                    tx_d    = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = STOP;
                    rd_en_d = tx_en_i && !fifo_E_i && !hold_valid_q;
                end
            end
`endif

            STOP: begin
                tx_d = 1'b1;
                if (baud_tick_i && cnt_q == STOP_LAST) begin
                    tx_done = 1'b1;
                    if (hold_valid_q || pop_dly_q) begin
                        // Chain straight into the next start bit. The byte
                        // comes from the hold register, or straight off the
                        // FIFO when the prefetch lands on this very cycle.
                        shift_d      = hold_valid_q ? hold_q
                                                    : fifo_rd_data_i[DATA_BITS-1:0];
                        hold_valid_d = 1'b0;
                        tx_d         = 1'b0;
                        state_d      = START;
`ifdef UART_TX_PARITY_EN
                        par_d        = parity_odd_i;
`endif
                    end else if (rd_en_q) begin
                        // Pop issued this cycle: data arrives next cycle.
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (baud_tick_i) cnt_d = cnt_q + 4'd1;
                    if (pop_dly_q) begin
                        hold_d       = fifo_rd_data_i[DATA_BITS-1:0];
                        hold_valid_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign rd_en_o   = rd_en_q;
    assign tx_o      = tx_q;
    assign tx_stat_o = {tx_done, (state_q != IDLE) && (state_q != FETCH)};

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//   Self-checking bench for uart_tx. A FIFO model feeds the DUT, a line
//   monitor decodes frames at each baud tick, and every byte pushed into the
//   FIFO model is also pushed onto an expected-byte queue that is popped and
//   compared when the monitor delivers a frame.
// ----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DATA_BITS + 1;
`else
    localparam int NB = DATA_BITS;
`endif

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       baud_tick_i;
    logic       tx_en_i;
    logic       fifo_E_i;
    logic [7:0] fifo_rd_data_i;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd_i;
`endif
    logic       rd_en_o;
    logic       tx_o;
    logic [1:0] tx_stat_o;

    uart_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(1)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .baud_tick_i    (baud_tick_i),
        .tx_en_i        (tx_en_i),
        .fifo_E_i       (fifo_E_i),
        .fifo_rd_data_i (fifo_rd_data_i),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i   (parity_odd_i),
`endif
        .rd_en_o        (rd_en_o),
        .tx_o           (tx_o),
        .tx_stat_o      (tx_stat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         gap;
        time        start_t;
        time        stop_t;
    } rx_t;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    rx_t        rx_q[$];
    time        pop_t[$];
    int         pop_cnt   = 0;
    int         pop_empty = 0;
    int         done_cnt  = 0;
    int         n_total   = 0;
    int         n_pass    = 0;
    int         mon_st    = 0;
    int         mon_n     = 0;
    int         idle_cnt  = 0;
    logic       tick_seen = 1'b0;
    rx_t        cur;

    // Baud tick: one cycle in sixteen, driven just after the active edge.
    initial begin
        int tick_cnt;
        tick_cnt    = 0;
        baud_tick_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            tick_cnt    = (tick_cnt == 15) ? 0 : tick_cnt + 1;
            baud_tick_i = (tick_cnt == 15);
        end
    end

    always @(posedge clk_i) tick_seen <= baud_tick_i;

    // FIFO model: a pop seen in cycle C presents its byte from mid-C onward,
    // so it is stable through cycle C+1.
    initial begin
        fifo_E_i       = 1'b1;
        fifo_rd_data_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rd_en_o === 1'b1) begin
                pop_cnt++;
                pop_t.push_back($time);
                if (fifo_q.size() == 0) pop_empty++;
                else fifo_rd_data_i = fifo_q.pop_front();
            end
            if (tx_stat_o[1] === 1'b1) done_cnt++;
            fifo_E_i = (fifo_q.size() == 0);
        end
    end

    // Line monitor: samples tx_o once per bit period, after each tick.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                mon_st   = 0;
                mon_n    = 0;
                idle_cnt = 0;
            end else if (tick_seen) begin
                case (mon_st)
                    0: begin
                        if (tx_o === 1'b0) begin
                            mon_st      = 1;
                            mon_n       = 0;
                            cur.gap     = idle_cnt;
                            cur.start_t = $time;
                            cur.par     = 1'bx;
                        end else begin
                            idle_cnt++;
                        end
                    end
                    1: begin
                        if (mon_n < DATA_BITS) cur.data[mon_n] = tx_o;
                        else cur.par = tx_o;
                        mon_n++;
                        if (mon_n == NB) mon_st = 2;
                    end
                    default: begin
                        cur.stop   = tx_o;
                        cur.stop_t = $time;
                        rx_q.push_back(cur);
                        idle_cnt   = 0;
                        mon_st     = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_rx(input int budget, output rx_t r, output bit got);
        got = 1'b0;
        r   = '{data: 8'hxx, par: 1'bx, stop: 1'bx, gap: -1, start_t: 0, stop_t: 0};
        for (int i = 0; i < budget && rx_q.size() == 0; i++) @(posedge clk_i);
        if (rx_q.size() > 0) begin
            r   = rx_q.pop_front();
            got = 1'b1;
        end
        #1;
    endtask

    task automatic wait_data_bit(input int n, output bit got);
        got = 1'b0;
        for (int i = 0; i < 2000 && !(mon_st == 1 && mon_n >= n); i++) @(posedge clk_i);
        got = (mon_st == 1 && mon_n >= n);
    endtask

    task automatic test_reset;
        rstn_i  = 1'b0;
        tx_en_i = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        n_total++;
        if (tx_o !== 1'b1) $display("FAIL reset_tx: got %b exp 1", tx_o);
        else n_pass++;
        n_total++;
        if (rd_en_o !== 1'b0) $display("FAIL reset_rd_en: got %b exp 0", rd_en_o);
        else n_pass++;
        n_total++;
        if (tx_stat_o !== 2'b00) $display("FAIL reset_stat: got %b exp 00", tx_stat_o);
        else n_pass++;
        rstn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_single;
        rx_t        r;
        bit         got;
        int         p0, d0;
        logic [7:0] e;
        p0 = pop_cnt;
        d0 = done_cnt;
        tx_en_i = 1'b1;
        push_byte(8'hA5);
        wait_rx(800, r, got);
        e = exp_q.pop_front();
        n_total++;
        if (!got || r.data !== e) $display("FAIL single_data: got %h exp %h", r.data, e);
        else n_pass++;
        n_total++;
        if ({r.stop, r.data, 1'b0} !== 10'b1_1010_0101_0)
            $display("FAIL single_bits: got %b exp 1101001010", {r.stop, r.data, 1'b0});
        else n_pass++;
        n_total++;
        if (tx_stat_o[0] !== 1'b1) $display("FAIL single_busy_in_stop: got %b exp 1", tx_stat_o[0]);
        else n_pass++;
        repeat (40) @(posedge clk_i);
        #1;
        n_total++;
        if (tx_stat_o !== 2'b00 || tx_o !== 1'b1)
            $display("FAIL single_idle_after: stat %b tx %b exp 00 1", tx_stat_o, tx_o);
        else n_pass++;
        n_total++;
        if (pop_cnt - p0 !== 1) $display("FAIL single_pops: got %0d exp 1", pop_cnt - p0);
        else n_pass++;
        n_total++;
        if (done_cnt - d0 !== 1) $display("FAIL single_done: got %0d exp 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        rx_t        r1, r2;
        bit         g1, g2;
        int         p0;
        logic [7:0] e;
        p0 = pop_cnt;
        push_byte(8'h12);
        push_byte(8'h34);
        wait_rx(800, r1, g1);
        e = exp_q.pop_front();
        n_total++;
        if (!g1 || r1.data !== e || r1.stop !== 1'b1)
            $display("FAIL b2b_first: got %h stop %b exp %h stop 1", r1.data, r1.stop, e);
        else n_pass++;
        wait_rx(400, r2, g2);
        e = exp_q.pop_front();
        n_total++;
        if (!g2 || r2.data !== e || r2.stop !== 1'b1)
            $display("FAIL b2b_second: got %h stop %b exp %h stop 1", r2.data, r2.stop, e);
        else n_pass++;
        n_total++;
        if (r2.gap !== 0) $display("FAIL b2b_gap: got %0d idle bit periods exp 0", r2.gap);
        else n_pass++;
        repeat (40) @(posedge clk_i);
        #1;
        n_total++;
        if (pop_cnt - p0 !== 2) $display("FAIL b2b_pops: got %0d exp 2", pop_cnt - p0);
        else n_pass++;
        n_total++;
        if (pop_t.size() < p0 + 2 || pop_t[p0+1] < r1.stop_t || pop_t[p0+1] >= r2.start_t)
            $display("FAIL b2b_prefetch_time: second pop at %0t exp within [%0t,%0t)",
                     (pop_t.size() >= p0 + 2) ? pop_t[p0+1] : 0, r1.stop_t, r2.start_t);
        else n_pass++;
    endtask

    task automatic test_empty;
        int p0, bad_tx, bad_stat;
        p0       = pop_cnt;
        bad_tx   = 0;
        bad_stat = 0;
        tx_en_i  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) bad_tx++;
            if (tx_stat_o !== 2'b00) bad_stat++;
        end
        n_total++;
        if (pop_cnt - p0 !== 0) $display("FAIL empty_pops: got %0d exp 0", pop_cnt - p0);
        else n_pass++;
        n_total++;
        if (bad_tx !== 0) $display("FAIL empty_tx: got %0d cycles low exp 0", bad_tx);
        else n_pass++;
        n_total++;
        if (bad_stat !== 0) $display("FAIL empty_stat: got %0d cycles nonzero exp 0", bad_stat);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        rx_t        r;
        bit         got;
        int         p0;
        logic [7:0] e;
        p0 = pop_cnt;
        push_byte(8'h00);
        push_byte(8'h3C);
        wait_data_bit(4, got);
        repeat (3) @(posedge clk_i);
        #2;
        n_total++;
        if (!got || tx_o !== 1'b0) $display("FAIL rstmid_pre: reached %b tx %b exp 1 0", got, tx_o);
        else n_pass++;
        rstn_i = 1'b0;
        #1;
        n_total++;
        if (tx_o !== 1'b1 || tx_stat_o !== 2'b00)
            $display("FAIL rstmid_async: tx %b stat %b exp 1 00", tx_o, tx_stat_o);
        else n_pass++;
        repeat (20) @(posedge clk_i);
        #1;
        n_total++;
        if (pop_cnt - p0 !== 1 || rd_en_o !== 1'b0)
            $display("FAIL rstmid_pops: got %0d rd_en %b exp 1 0", pop_cnt - p0, rd_en_o);
        else n_pass++;
        e = exp_q.pop_front();
        rstn_i = 1'b1;
        wait_rx(800, r, got);
        e = exp_q.pop_front();
        n_total++;
        if (!got || r.data !== e || r.stop !== 1'b1)
            $display("FAIL rstmid_next: got %h stop %b exp %h stop 1", r.data, r.stop, e);
        else n_pass++;
        repeat (40) @(posedge clk_i);
        #1;
    endtask

    task automatic test_en_drop;
        rx_t        r;
        bit         got;
        int         p0;
        logic [7:0] e;
        p0 = pop_cnt;
        tx_en_i = 1'b1;
        push_byte(8'h55);
        push_byte(8'h66);
        wait_data_bit(2, got);
        tx_en_i = 1'b0;
        wait_rx(800, r, got);
        e = exp_q.pop_front();
        n_total++;
        if (!got || r.data !== e || r.stop !== 1'b1)
            $display("FAIL endrop_data: got %h stop %b exp %h stop 1", r.data, r.stop, e);
        else n_pass++;
        repeat (100) @(posedge clk_i);
        #1;
        n_total++;
        if (pop_cnt - p0 !== 1 || fifo_q.size() !== 1)
            $display("FAIL endrop_pops: got %0d left %0d exp 1 1", pop_cnt - p0, fifo_q.size());
        else n_pass++;
        n_total++;
        if (rx_q.size() !== 0 || tx_o !== 1'b1 || tx_stat_o !== 2'b00)
            $display("FAIL endrop_idle: frames %0d tx %b stat %b exp 0 1 00",
                     rx_q.size(), tx_o, tx_stat_o);
        else n_pass++;
        fifo_q.delete();
        e = exp_q.pop_front();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        rx_t        r;
        bit         got;
        logic [7:0] e;
        logic       ep;
        tx_en_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            parity_odd_i = (k == 1);
            push_byte(8'h07);
            wait_rx(900, r, got);
            e  = exp_q.pop_front();
            ep = (^e) ^ parity_odd_i;
            n_total++;
            if (!got || r.data !== e || r.par !== ep || r.stop !== 1'b1)
                $display("FAIL parity_%0d: data %h par %b stop %b exp %h %b 1",
                         k, r.data, r.par, r.stop, e, ep);
            else n_pass++;
            repeat (40) @(posedge clk_i);
            #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_reset_mid();
        test_en_drop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        n_total++;
        if (pop_empty !== 0) $display("FAIL pop_while_empty: got %0d exp 0", pop_empty);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
